// File: rtl/ram_slot_allocator.sv
// RAM slot allocator: owns the slot valid vector, grants the lowest free slot
// on request and retires slots on free, keeping a registered free-slot count.
module ram_slot_allocator #(
  parameter int unsigned SIZE_RAM     = 32,
  parameter int unsigned SIZE_RAM_LOG = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    AllocReq,
  output logic                    AllocGnt,
  output logic [SIZE_RAM_LOG-1:0] AllocIdx,
  output logic                    AllocDeny,
  input  logic                    FreeReq,
  input  logic [SIZE_RAM_LOG-1:0] FreeIdx,
  output logic                    FreeErr,
  output logic [SIZE_RAM-1:0]     RamValid,
  output logic [SIZE_RAM_LOG:0]   FreeCount,
  output logic                    Full,
  output logic                    Empty
);

  localparam int unsigned CNT_W = SIZE_RAM_LOG + 1;

  typedef enum logic [0:0] {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t                  state_q, state_d;
  logic [SIZE_RAM-1:0]     valid_d;
  logic [SIZE_RAM_LOG-1:0] idx_d;
  logic [CNT_W-1:0]        count_d;
  logic                    gnt_d, deny_d, err_d, full_d, empty_d;
  logic [SIZE_RAM_LOG-1:0] search_idx_c;
  logic                    found_c;
  logic                    alloc_ok_c, free_ok_c;

  // First-zero search: number of consecutive ones from bit 0 (0 when all set).
  always_comb begin
    search_idx_c = '0;
    found_c      = 1'b0;
    for (int unsigned i = 0; i < SIZE_RAM; i++) begin
      if (!found_c && !RamValid[SIZE_RAM_LOG'(i)]) begin
        search_idx_c = SIZE_RAM_LOG'(i);
        found_c      = 1'b1;
      end
    end
  end

  // Next-state and next-output logic; allocation always sees the pre-free vector.
  always_comb begin
    state_d    = state_q;
    valid_d    = RamValid;
    idx_d      = AllocIdx;
    count_d    = FreeCount;
    full_d     = Full;
    empty_d    = Empty;
    gnt_d      = 1'b0;
    deny_d     = 1'b0;
    err_d      = 1'b0;
    alloc_ok_c = 1'b0;
    free_ok_c  = 1'b0;
    case (state_q)
      ST_INIT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        alloc_ok_c = AllocReq && !Full;
        free_ok_c  = FreeReq && RamValid[FreeIdx];
        deny_d     = AllocReq && Full;
        err_d      = FreeReq && !RamValid[FreeIdx];
        gnt_d      = alloc_ok_c;
        if (alloc_ok_c) begin
          valid_d[search_idx_c] = 1'b1;
          idx_d                 = search_idx_c;
        end
        if (free_ok_c) begin
          valid_d[FreeIdx] = 1'b0;
        end
        count_d = FreeCount - CNT_W'(alloc_ok_c) + CNT_W'(free_ok_c);
        full_d  = (count_d == '0);
        empty_d = (count_d == CNT_W'(SIZE_RAM));
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_INIT;
      RamValid  <= '0;
      FreeCount <= CNT_W'(SIZE_RAM);
      Full      <= 1'b0;
      Empty     <= 1'b1;
      AllocGnt  <= 1'b0;
      AllocIdx  <= '0;
      AllocDeny <= 1'b0;
      FreeErr   <= 1'b0;
    end else begin
      state_q   <= state_d;
      RamValid  <= valid_d;
      FreeCount <= count_d;
      Full      <= full_d;
      Empty     <= empty_d;
      AllocGnt  <= gnt_d;
      AllocIdx  <= idx_d;
      AllocDeny <= deny_d;
      FreeErr   <= err_d;
    end
  end

  // The free count must always mirror the number of empty slots.
  a_count_matches : assert property (@(posedge clk) disable iff (rst)
    FreeCount == CNT_W'(SIZE_RAM - $countones(RamValid)));

endmodule

// File: tb/tb_ram_slot_allocator.sv
// Self-checking bench for ram_slot_allocator: directed scenarios plus random
// traffic compared against an array-based slot model.
module tb_ram_slot_allocator;

  localparam int unsigned N  = 32;
  localparam int unsigned LG = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          AllocReq = 1'b0;
  logic          FreeReq = 1'b0;
  logic [LG-1:0] FreeIdx = '0;
  logic          AllocGnt, AllocDeny, FreeErr, Full, Empty;
  logic [LG-1:0] AllocIdx;
  logic [N-1:0]  RamValid;
  logic [LG:0]   FreeCount;

  int checks = 0;
  int errors = 0;

  // Reference model: occupancy array plus the expected output pulses.
  bit            mv[N];
  bit            m_init;
  bit            m_gnt, m_deny, m_err;
  logic [LG-1:0] m_idx;

  ram_slot_allocator #(.SIZE_RAM(N), .SIZE_RAM_LOG(LG)) dut (
    .clk(clk), .rst(rst),
    .AllocReq(AllocReq), .AllocGnt(AllocGnt), .AllocIdx(AllocIdx), .AllocDeny(AllocDeny),
    .FreeReq(FreeReq), .FreeIdx(FreeIdx), .FreeErr(FreeErr),
    .RamValid(RamValid), .FreeCount(FreeCount), .Full(Full), .Empty(Empty)
  );

  always #5 clk = ~clk;

  function automatic int m_free_slots();
    int z = 0;
    for (int i = 0; i < N; i++) if (!mv[i]) z++;
    return z;
  endfunction

  function automatic logic [N-1:0] m_vec();
    logic [N-1:0] v = '0;
    for (int i = 0; i < N; i++) v[i] = mv[i];
    return v;
  endfunction

  // Apply one cycle of inputs, advance the model, sample #1 after the edge.
  task automatic cyc(input bit r, input bit a, input bit f, input int fi);
    int  lowest;
    bit  was_full;
    rst = r; AllocReq = a; FreeReq = f; FreeIdx = LG'(fi);
    m_gnt = 0; m_deny = 0; m_err = 0;
    if (r) begin
      for (int i = 0; i < N; i++) mv[i] = 0;
      m_idx = '0;
      m_init = 1;
    end else if (m_init) begin
      m_init = 0;
    end else begin
      was_full = (m_free_slots() == 0);
      lowest = -1;
      for (int i = N - 1; i >= 0; i--) if (!mv[i]) lowest = i;
      m_deny = a && was_full;
      m_gnt  = a && !was_full;
      m_err  = f && !mv[fi];
      if (f && mv[fi]) mv[fi] = 0;
      if (m_gnt) begin
        mv[lowest] = 1;
        m_idx = LG'(lowest);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cyc(1, 1, 1, 0);
    cyc(1, 1, 1, 0);
    checks++;
    if (RamValid !== '0 || FreeCount !== 6'd32 || Empty !== 1'b1 || Full !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: valid=%h count=%0d empty=%b full=%b, required 0/32/1/0",
               RamValid, FreeCount, Empty, Full);
    end
    checks++;
    if (AllocGnt !== 1'b0 || AllocIdx !== '0 || AllocDeny !== 1'b0 || FreeErr !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulses: gnt=%b idx=%0d deny=%b err=%b, required all 0",
               AllocGnt, AllocIdx, AllocDeny, FreeErr);
    end
    cyc(0, 1, 1, 4);
    checks++;
    if (AllocGnt !== 1'b0 || AllocDeny !== 1'b0 || FreeErr !== 1'b0 || RamValid !== '0) begin
      errors++;
      $display("FAIL init_ignores: gnt=%b deny=%b err=%b valid=%h, required 0/0/0/0",
               AllocGnt, AllocDeny, FreeErr, RamValid);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < N; i++) begin
      cyc(0, 1, 0, 0);
      checks++;
      if (AllocGnt !== 1'b1 || AllocIdx !== LG'(i) || FreeCount !== 6'(N - 1 - i)) begin
        errors++;
        $display("FAIL fill_%0d: gnt=%b idx=%0d count=%0d, required 1/%0d/%0d",
                 i, AllocGnt, AllocIdx, FreeCount, i, N - 1 - i);
      end
    end
    checks++;
    if (Full !== 1'b1 || Empty !== 1'b0 || RamValid !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL fill_full: full=%b empty=%b valid=%h, required 1/0/ffffffff",
               Full, Empty, RamValid);
    end
  endtask

  task automatic test_full_deny();
    cyc(0, 1, 0, 0);
    checks++;
    if (AllocDeny !== 1'b1 || AllocGnt !== 1'b0 || RamValid !== 32'hFFFF_FFFF
        || AllocIdx !== 5'd31 || FreeCount !== 6'd0) begin
      errors++;
      $display("FAIL full_deny: deny=%b gnt=%b valid=%h idx=%0d count=%0d, required 1/0/ffffffff/31/0",
               AllocDeny, AllocGnt, RamValid, AllocIdx, FreeCount);
    end
  endtask

  task automatic test_free_realloc();
    cyc(0, 0, 1, 7);
    checks++;
    if (FreeCount !== 6'd1 || RamValid[7] !== 1'b0 || Full !== 1'b0 || FreeErr !== 1'b0) begin
      errors++;
      $display("FAIL free7: count=%0d bit7=%b full=%b err=%b, required 1/0/0/0",
               FreeCount, RamValid[7], Full, FreeErr);
    end
    cyc(0, 1, 0, 0);
    checks++;
    if (AllocGnt !== 1'b1 || AllocIdx !== 5'd7 || FreeCount !== 6'd0 || Full !== 1'b1) begin
      errors++;
      $display("FAIL realloc7: gnt=%b idx=%0d count=%0d full=%b, required 1/7/0/1",
               AllocGnt, AllocIdx, FreeCount, Full);
    end
  endtask

  task automatic test_simultaneous();
    cyc(0, 1, 1, 3);
    checks++;
    if (AllocDeny !== 1'b1 || AllocGnt !== 1'b0 || RamValid !== 32'hFFFF_FFF7 || FreeCount !== 6'd1) begin
      errors++;
      $display("FAIL simul_deny: deny=%b gnt=%b valid=%h count=%0d, required 1/0/fffffff7/1",
               AllocDeny, AllocGnt, RamValid, FreeCount);
    end
    cyc(0, 1, 0, 0);
    checks++;
    if (AllocGnt !== 1'b1 || AllocIdx !== 5'd3 || Full !== 1'b1) begin
      errors++;
      $display("FAIL simul_regrant: gnt=%b idx=%0d full=%b, required 1/3/1",
               AllocGnt, AllocIdx, Full);
    end
  endtask

  task automatic test_free_err();
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 9);
    checks++;
    if (FreeErr !== 1'b1 || RamValid !== 32'h0000_000F || FreeCount !== 6'd28) begin
      errors++;
      $display("FAIL free_err: err=%b valid=%h count=%0d, required 1/0000000f/28",
               FreeErr, RamValid, FreeCount);
    end
    cyc(0, 0, 1, 2);
    checks++;
    if (FreeErr !== 1'b0 || RamValid !== 32'h0000_000B) begin
      errors++;
      $display("FAIL free2: err=%b valid=%h, required 0/0000000b", FreeErr, RamValid);
    end
    cyc(0, 1, 0, 0);
    checks++;
    if (AllocGnt !== 1'b1 || AllocIdx !== 5'd2 || RamValid !== 32'h0000_000F) begin
      errors++;
      $display("FAIL regrant2: gnt=%b idx=%0d valid=%h, required 1/2/0000000f",
               AllocGnt, AllocIdx, RamValid);
    end
  endtask

  task automatic test_reset_inflight();
    cyc(0, 1, 0, 0);
    cyc(1, 1, 1, 0);
    checks++;
    if (AllocGnt !== 1'b0 || RamValid !== '0 || FreeCount !== 6'd32) begin
      errors++;
      $display("FAIL rst_inflight: gnt=%b valid=%h count=%0d, required 0/0/32",
               AllocGnt, RamValid, FreeCount);
    end
    cyc(0, 1, 1, 0);
    checks++;
    if (AllocGnt !== 1'b0 || AllocDeny !== 1'b0 || FreeErr !== 1'b0 || RamValid !== '0) begin
      errors++;
      $display("FAIL rst_init_quiet: gnt=%b deny=%b err=%b valid=%h, required 0/0/0/0",
               AllocGnt, AllocDeny, FreeErr, RamValid);
    end
  endtask

  task automatic test_random();
    int p_alloc;
    int fi;
    for (int c = 0; c < 1200; c++) begin
      p_alloc = ((c / 150) % 2 == 0) ? 80 : 25;
      fi = int'($urandom_range(0, N - 1));
      cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 99) < p_alloc),
          ($urandom_range(0, 99) < 50), fi);
      checks++;
      if (RamValid !== m_vec() || FreeCount !== 6'(m_free_slots())
          || Full !== (m_free_slots() == 0) || Empty !== (m_free_slots() == N)
          || AllocGnt !== m_gnt || AllocDeny !== m_deny || FreeErr !== m_err
          || AllocIdx !== m_idx) begin
        errors++;
        $display("FAIL random_%0d: valid=%h cnt=%0d full=%b empty=%b gnt=%b idx=%0d deny=%b err=%b, required valid=%h cnt=%0d gnt=%b idx=%0d deny=%b err=%b",
                 c, RamValid, FreeCount, Full, Empty, AllocGnt, AllocIdx, AllocDeny, FreeErr,
                 m_vec(), m_free_slots(), m_gnt, m_idx, m_deny, m_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_deny();
    test_free_realloc();
    test_simultaneous();
    test_free_err();
    test_reset_inflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
